// File: rtl/riscv_test_checker_if.sv
// rtl/riscv_test_checker_if.sv - table-load, core-observe and status signals of riscv_test_checker
interface riscv_test_checker_if #(
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
);
    logic              TBL_WE;
    logic [IDX_W-1:0]  TBL_IDX;
    logic [CNT_W-1:0]  TBL_NUM_INST;
    logic [DATA_W-1:0] TBL_ANS;
    logic              START;
    logic              HALT;
    logic [CNT_W-1:0]  NUM_INST;
    logic [DATA_W-1:0] OUTPUT_PORT;
    logic              BUSY;
    logic              DONE;
    logic              SUCCESS;
    logic              FAIL;
    logic [IDX_W:0]    PASS_CNT;
    logic [IDX_W:0]    FAIL_CNT;
    logic [IDX_W-1:0]  FAIL_IDX;
    logic [DATA_W-1:0] FAIL_VAL;
    logic [CNT_W-1:0]  CYCLE;

    modport master (
        output TBL_WE, TBL_IDX, TBL_NUM_INST, TBL_ANS, START, HALT, NUM_INST, OUTPUT_PORT,
        input  BUSY, DONE, SUCCESS, FAIL, PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, CYCLE
    );

    modport slave (
        input  TBL_WE, TBL_IDX, TBL_NUM_INST, TBL_ANS, START, HALT, NUM_INST, OUTPUT_PORT,
        output BUSY, DONE, SUCCESS, FAIL, PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, CYCLE
    );
endinterface

// File: rtl/riscv_test_checker.sv
// rtl/riscv_test_checker.sv - checks core OUTPUT_PORT against a loadable (instruction-count, value) table
module riscv_test_checker #(
    parameter int NUM_TEST     = 40,
    parameter int IDX_W        = 6,
    parameter int CNT_W        = 32,
    parameter int DATA_W       = 32,
    parameter int STOP_ON_FAIL = 1
) (
    input logic                 CLK,
    input logic                 RST,
    riscv_test_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPED, DONE_S} state_t;

    localparam logic [IDX_W:0] NUM_TEST_W = (IDX_W+1)'(NUM_TEST);

    state_t            state;
    logic [CNT_W-1:0]  tbl_num [NUM_TEST];
    logic [DATA_W-1:0] tbl_ans [NUM_TEST];
    logic [NUM_TEST-1:0] armed, resolved, passed;
    logic [NUM_TEST-1:0] hit, hit_pass, hit_fail;
    logic [IDX_W:0]    n_pass, n_fail;
    logic [IDX_W-1:0]  first_fail;
    logic              wr_ok;

    logic              done, success, fail_seen;
    logic [IDX_W:0]    pass_cnt, fail_cnt;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] fail_val;
    logic [CNT_W-1:0]  cycle;

    assign wr_ok = bus.TBL_WE && (state == IDLE) && ({1'b0, bus.TBL_IDX} < NUM_TEST_W);

    // Table contents survive reset; only the armed bits are cleared.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            tbl_num[bus.TBL_IDX] <= bus.TBL_NUM_INST;
            tbl_ans[bus.TBL_IDX] <= bus.TBL_ANS;
        end
    end

    // Descending scan so the lowest failing index is the one left in first_fail.
    always_comb begin
        hit        = '0;
        hit_pass   = '0;
        hit_fail   = '0;
        n_pass     = '0;
        n_fail     = '0;
        first_fail = '0;
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            hit[i]      = armed[i] && !resolved[i] && (tbl_num[i] == bus.NUM_INST);
            hit_pass[i] = hit[i] && (tbl_ans[i] == bus.OUTPUT_PORT);
            hit_fail[i] = hit[i] && !hit_pass[i];
            n_pass      = n_pass + {{IDX_W{1'b0}}, hit_pass[i]};
            n_fail      = n_fail + {{IDX_W{1'b0}}, hit_fail[i]};
            if (hit_fail[i]) first_fail = IDX_W'(i);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            armed     <= '0;
            resolved  <= '0;
            passed    <= '0;
            done      <= 1'b0;
            success   <= 1'b0;
            fail_seen <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
            fail_val  <= '0;
            cycle     <= '0;
        end else begin
            if (wr_ok) armed[bus.TBL_IDX] <= 1'b1;

            if (state == RUN) begin
                cycle    <= (cycle == '1) ? cycle : cycle + 1'b1;
                resolved <= resolved | hit;
                passed   <= passed | hit_pass;
                pass_cnt <= pass_cnt + n_pass;
                fail_cnt <= fail_cnt + n_fail;
                if (|hit_fail && !fail_seen) begin
                    fail_seen <= 1'b1;
                    fail_idx  <= first_fail;
                    fail_val  <= bus.OUTPUT_PORT;
                end
                // A failure in stop mode wins over a simultaneous HALT.
                if (|hit_fail && (STOP_ON_FAIL != 0)) begin
                    state   <= STOPPED;
                    done    <= 1'b1;
                    success <= 1'b0;
                end else if (bus.HALT) begin
                    state   <= DONE_S;
                    done    <= 1'b1;
                    success <= !fail_seen && !(|hit_fail) && ((passed | hit_pass) == armed);
                end
            end else if (bus.START) begin
                state     <= RUN;
                resolved  <= '0;
                passed    <= '0;
                done      <= 1'b0;
                success   <= 1'b0;
                fail_seen <= 1'b0;
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                fail_idx  <= '0;
                fail_val  <= '0;
                cycle     <= '0;
            end
        end
    end

    assign bus.BUSY     = (state == RUN);
    assign bus.DONE     = done;
    assign bus.SUCCESS  = success;
    assign bus.FAIL     = fail_seen;
    assign bus.PASS_CNT = pass_cnt;
    assign bus.FAIL_CNT = fail_cnt;
    assign bus.FAIL_IDX = fail_idx;
    assign bus.FAIL_VAL = fail_val;
    assign bus.CYCLE    = cycle;
endmodule

// File: tb/tb_riscv_test_checker.sv
// tb/tb_riscv_test_checker.sv - scoreboard bench for riscv_test_checker in stop and continue modes
module tb_riscv_test_checker;
    localparam int NUM_TEST = 40;
    localparam int IDX_W    = 6;
    localparam int CNT_W    = 32;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              success;
        logic              flag;
        logic [IDX_W:0]    pass_cnt;
        logic [IDX_W:0]    fail_cnt;
        logic [IDX_W-1:0]  fail_idx;
        logic [DATA_W-1:0] fail_val;
        logic [CNT_W-1:0]  cycle;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              tbl_we = 1'b0;
    logic [IDX_W-1:0]  tbl_idx = '0;
    logic [CNT_W-1:0]  tbl_num_inst = '0;
    logic [DATA_W-1:0] tbl_ans = '0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic [CNT_W-1:0]  num_inst = '0;
    logic [DATA_W-1:0] output_port = '0;

    riscv_test_checker_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus_s ();
    riscv_test_checker_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus_c ();

    assign bus_s.TBL_WE = tbl_we;           assign bus_c.TBL_WE = tbl_we;
    assign bus_s.TBL_IDX = tbl_idx;         assign bus_c.TBL_IDX = tbl_idx;
    assign bus_s.TBL_NUM_INST = tbl_num_inst; assign bus_c.TBL_NUM_INST = tbl_num_inst;
    assign bus_s.TBL_ANS = tbl_ans;         assign bus_c.TBL_ANS = tbl_ans;
    assign bus_s.START = start;             assign bus_c.START = start;
    assign bus_s.HALT = halt;               assign bus_c.HALT = halt;
    assign bus_s.NUM_INST = num_inst;       assign bus_c.NUM_INST = num_inst;
    assign bus_s.OUTPUT_PORT = output_port; assign bus_c.OUTPUT_PORT = output_port;

    riscv_test_checker #(.NUM_TEST(NUM_TEST), .IDX_W(IDX_W), .CNT_W(CNT_W), .DATA_W(DATA_W),
                         .STOP_ON_FAIL(1)) dut_s (.CLK(clk), .RST(rst), .bus(bus_s.slave));
    riscv_test_checker #(.NUM_TEST(NUM_TEST), .IDX_W(IDX_W), .CNT_W(CNT_W), .DATA_W(DATA_W),
                         .STOP_ON_FAIL(0)) dut_c (.CLK(clk), .RST(rst), .bus(bus_c.slave));

    snap_t act [2];
    assign act[0] = {bus_s.BUSY, bus_s.DONE, bus_s.SUCCESS, bus_s.FAIL, bus_s.PASS_CNT,
                     bus_s.FAIL_CNT, bus_s.FAIL_IDX, bus_s.FAIL_VAL, bus_s.CYCLE};
    assign act[1] = {bus_c.BUSY, bus_c.DONE, bus_c.SUCCESS, bus_c.FAIL, bus_c.PASS_CNT,
                     bus_c.FAIL_CNT, bus_c.FAIL_IDX, bus_c.FAIL_VAL, bus_c.CYCLE};

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 mirrors the stop-on-fail checker, index 1 the continue checker.
    typedef enum int {M_IDLE, M_RUN, M_STOPPED, M_DONE} mstate_t;
    mstate_t           m_st [2];
    logic [CNT_W-1:0]  m_num [2][NUM_TEST];
    logic [DATA_W-1:0] m_ans [2][NUM_TEST];
    bit                m_arm [2][NUM_TEST];
    bit                m_chk [2][NUM_TEST];
    int                m_pass [2];
    int                m_fails [2];
    bit                m_flag [2];
    bit                m_done [2];
    bit                m_succ [2];
    int                m_fidx [2];
    logic [DATA_W-1:0] m_fval [2];
    logic [CNT_W-1:0]  m_cyc [2];

    snap_t exp_q0 [$];
    snap_t exp_q1 [$];

    task automatic clear_run(input int m);
        for (int i = 0; i < NUM_TEST; i++) m_chk[m][i] = 1'b0;
        m_pass[m] = 0; m_fails[m] = 0; m_flag[m] = 1'b0; m_done[m] = 1'b0;
        m_succ[m] = 1'b0; m_fidx[m] = 0; m_fval[m] = '0; m_cyc[m] = '0;
    endtask

    task automatic model_reset(input int m);
        clear_run(m);
        for (int i = 0; i < NUM_TEST; i++) m_arm[m][i] = 1'b0;
        m_st[m] = M_IDLE;
    endtask

    task automatic model_edge(input int m);
        int np, nf, first, narmed;
        if (rst) begin
            model_reset(m);
            return;
        end
        if (m_st[m] == M_IDLE && tbl_we && int'(tbl_idx) < NUM_TEST) begin
            m_num[m][tbl_idx] = tbl_num_inst;
            m_ans[m][tbl_idx] = tbl_ans;
            m_arm[m][tbl_idx] = 1'b1;
        end
        if (m_st[m] == M_RUN) begin
            np = 0; nf = 0; first = -1; narmed = 0;
            if (m_cyc[m] != '1) m_cyc[m] = m_cyc[m] + 1;
            for (int i = 0; i < NUM_TEST; i++) begin
                if (m_arm[m][i]) narmed++;
                if (m_arm[m][i] && !m_chk[m][i] && m_num[m][i] == num_inst) begin
                    m_chk[m][i] = 1'b1;
                    if (m_ans[m][i] == output_port) np++;
                    else begin
                        nf++;
                        if (first < 0) first = i;
                    end
                end
            end
            m_pass[m] += np;
            m_fails[m] += nf;
            if (nf > 0 && !m_flag[m]) begin
                m_flag[m] = 1'b1;
                m_fidx[m] = first;
                m_fval[m] = output_port;
            end
            if (nf > 0 && m == 0) begin
                m_st[m] = M_STOPPED; m_done[m] = 1'b1; m_succ[m] = 1'b0;
            end else if (halt) begin
                m_st[m] = M_DONE; m_done[m] = 1'b1;
                m_succ[m] = !m_flag[m] && (m_pass[m] == narmed);
            end
        end else if (start) begin
            clear_run(m);
            m_st[m] = M_RUN;
        end
    endtask

    function automatic snap_t model_snap(input int m);
        snap_t s;
        s.busy     = (m_st[m] == M_RUN);
        s.done     = m_done[m];
        s.success  = m_succ[m];
        s.flag     = m_flag[m];
        s.pass_cnt = (IDX_W+1)'(m_pass[m]);
        s.fail_cnt = (IDX_W+1)'(m_fails[m]);
        s.fail_idx = IDX_W'(m_fidx[m]);
        s.fail_val = m_fval[m];
        s.cycle    = m_cyc[m];
        return s;
    endfunction

    // Predict each edge, then account for a reset that the driver asserts asynchronously just after it.
    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
        #2;
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end
        exp_q0.push_back(model_snap(0));
        exp_q1.push_back(model_snap(1));
    end

    task automatic compare(input int d, input snap_t e, input snap_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL snapshot dut%0d t=%0t got busy=%b done=%b succ=%b flag=%b pass=%0d nfail=%0d idx=%0d val=%h cyc=%0d expected busy=%b done=%b succ=%b flag=%b pass=%0d nfail=%0d idx=%0d val=%h cyc=%0d",
                     d, $time, a.busy, a.done, a.success, a.flag, a.pass_cnt, a.fail_cnt, a.fail_idx,
                     a.fail_val, a.cycle, e.busy, e.done, e.success, e.flag, e.pass_cnt, e.fail_cnt,
                     e.fail_idx, e.fail_val, e.cycle);
        end
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            compare(0, e, act[0]);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            compare(1, e, act[1]);
        end
    end

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tbl_we = 1'b0; start = 1'b0; halt = 1'b0;
        num_inst = '0; output_port = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load(input int idx, input logic [CNT_W-1:0] n, input logic [DATA_W-1:0] a);
        tbl_we = 1'b1; tbl_idx = IDX_W'(idx); tbl_num_inst = n; tbl_ans = a;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [CNT_W-1:0] n, input logic [DATA_W-1:0] o, input int cycles);
        num_inst = n; output_port = o;
        repeat (cycles) tick();
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    initial begin
        int nload;
        bit started;

        // Two matching entries then HALT.
        do_reset();
        load(0, 4, 32'h0f00);
        load(1, 6, 32'h0018);
        go();
        drive(4, 32'h0f00, 1);
        drive(6, 32'h0018, 1);
        do_halt();
        @(negedge clk);
        chk("pass_cnt_two", bus_c.PASS_CNT, 2);
        chk("done_two", bus_c.DONE, 1);
        chk("success_two", bus_c.SUCCESS, 1);
        chk("flag_two", bus_c.FAIL, 0);

        // Single mismatch: stop mode freezes, continue mode runs on.
        do_reset();
        load(5, 32'h0e, 32'h0);
        go();
        drive(32'h0e, 32'h3, 1);
        @(negedge clk);
        chk("stop_flag", bus_s.FAIL, 1);
        chk("stop_idx", bus_s.FAIL_IDX, 5);
        chk("stop_val", bus_s.FAIL_VAL, 3);
        chk("stop_done", bus_s.DONE, 1);
        chk("stop_success", bus_s.SUCCESS, 0);
        drive(32'h20, 32'h0, 3);
        do_halt();
        @(negedge clk);
        chk("stop_frozen_cycle", bus_s.CYCLE, 1);
        chk("cont_done_after_halt", bus_c.DONE, 1);

        // Two entries at one count, one passes and one fails.
        do_reset();
        load(2, 32'h10, 32'h1d);
        load(3, 32'h10, 32'h1e);
        go();
        drive(32'h10, 32'h1e, 2);
        @(negedge clk);
        chk("dual_pass", bus_c.PASS_CNT, 1);
        chk("dual_fails", bus_c.FAIL_CNT, 1);
        chk("dual_idx", bus_c.FAIL_IDX, 2);
        chk("dual_busy", bus_c.BUSY, 1);
        do_halt();
        @(negedge clk);
        chk("dual_success", bus_c.SUCCESS, 0);

        // Count held for several cycles is checked once.
        do_reset();
        load(0, 4, 32'h55);
        go();
        drive(4, 32'h55, 5);
        @(negedge clk);
        chk("hold_pass", bus_c.PASS_CNT, 1);
        chk("hold_cycle", bus_c.CYCLE, 5);
        do_halt();

        // Armed entry never reached.
        do_reset();
        load(7, 32'h1340, 32'h1);
        go();
        drive(32'h100, 32'h1, 1);
        do_halt();
        @(negedge clk);
        chk("unreached_done", bus_c.DONE, 1);
        chk("unreached_success", bus_c.SUCCESS, 0);
        chk("unreached_flag", bus_c.FAIL, 0);

        // Reset mid-run disarms the table.
        do_reset();
        load(1, 3, 32'h9);
        go();
        drive(2, 32'h0, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle", bus_c.CYCLE, 0);
        chk("rst_busy", bus_c.BUSY, 0);
        tick();
        rst = 1'b0;
        go();
        do_halt();
        @(negedge clk);
        chk("rst_pass", bus_c.PASS_CNT, 0);
        chk("rst_success", bus_c.SUCCESS, 1);

        // Random tables and traces, including restarts and write+START in one cycle.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            nload = $urandom_range(0, 6);
            started = 1'b0;
            for (int k = 0; k < nload; k++) begin
                tbl_we = 1'b1;
                tbl_idx = IDX_W'($urandom_range(0, 47));
                tbl_num_inst = CNT_W'($urandom_range(0, 12));
                tbl_ans = DATA_W'($urandom_range(0, 3));
                if (k == nload - 1 && $urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                    started = 1'b1;
                end
                tick();
                tbl_we = 1'b0;
                start = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!(p == 0 && started)) go();
                for (int c = 0; c < 15; c++) begin
                    num_inst = CNT_W'($urandom_range(0, 12));
                    output_port = DATA_W'($urandom_range(0, 3));
                    start = ($urandom_range(0, 9) == 0);
                    halt = (c == 14) || ($urandom_range(0, 19) == 0);
                    tick();
                end
                start = 1'b0;
                halt = 1'b0;
                tick();
            end
        end

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_test_checker.md
Name: riscv_test_checker

Overview:
- Synthesizable, parametrised checker for RISC-V core self-test runs; generalises the simulation-only pass/fail table into hardware.
- Sits beside RISCV_TOP and watches NUM_INST, OUTPUT_PORT and HALT.
- Holds a loadable table of (instruction-count, expected-value) entries and checks OUTPUT_PORT when NUM_INST hits each entry.
- Reports pass count, first-failure details, cycle count and final verdict; runs stop-on-first-fail or continue mode.

Parameters:
NUM_TEST, 40, number of table entries
IDX_W, 6, entry index width; must satisfy 2^IDX_W >= NUM_TEST
CNT_W, 32, width of NUM_INST, table instruction counts and CYCLE
DATA_W, 32, width of OUTPUT_PORT and expected values
STOP_ON_FAIL, 1, 1 = freeze on first mismatch; 0 = record and continue

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
TBL_WE  in  1  table write strobe; honoured in IDLE only
TBL_IDX  in  IDX_W  entry being written
TBL_NUM_INST  in  CNT_W  instruction count at which the entry is checked
TBL_ANS  in  DATA_W  expected OUTPUT_PORT value
START  in  1  begin (or restart) a run
HALT  in  1  core halt
NUM_INST  in  CNT_W  core retired-instruction count
OUTPUT_PORT  in  DATA_W  core output port
BUSY  out  1  high in RUN
DONE  out  1  run finished (HALT seen or first failure in stop mode)
SUCCESS  out  1  DONE, no failure, and every armed entry passed
FAIL  out  1  sticky: at least one mismatch this run
PASS_CNT  out  IDX_W+1  entries passed this run
FAIL_CNT  out  IDX_W+1  entries failed this run
FAIL_IDX  out  IDX_W  index of first failing entry
FAIL_VAL  out  DATA_W  OUTPUT_PORT captured at first failure
CYCLE  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; all outputs become 0.
  - Armed, passed and resolved bits are cleared.
  - Table contents are not reset.
  - Asserting RST mid-run aborts the run immediately.
- States are IDLE, RUN, STOPPED, DONE_S.
- IDLE:
  - TBL_WE writes the entry at TBL_IDX and sets its armed bit.
  - TBL_IDX >= NUM_TEST is ignored.
  - START moves to RUN.
  - If TBL_WE and START occur in the same cycle, the write completes first.
- START in IDLE, STOPPED or DONE_S:
  - Clears resolved/passed bits, PASS_CNT, FAIL_CNT, FAIL, FAIL_IDX, FAIL_VAL, CYCLE, DONE and SUCCESS.
  - Enters RUN the next cycle.
  - START in RUN is ignored.
- RUN, each cycle:
  - CYCLE increments and saturates at all-ones.
  - Every entry that is armed, unresolved and has TBL_NUM_INST == NUM_INST is evaluated in parallel.
    - Equal OUTPUT_PORT: entry becomes resolved and passed.
    - Unequal OUTPUT_PORT: entry becomes resolved and failed.
  - Each evaluated entry is checked once per run; later cycles with the same NUM_INST are ignored.
  - PASS_CNT and FAIL_CNT each add that cycle's number of passes/fails; multiple simultaneous matches are legal.
  - All status updates appear 1 cycle after the sampling edge.
- First failure of the run:
  - FAIL is set.
  - FAIL_IDX gets the lowest failing index of that cycle.
  - FAIL_VAL gets the OUTPUT_PORT value sampled in that cycle.
  - Later failures only increment FAIL_CNT.
- STOP_ON_FAIL=1: the first failure moves to STOPPED, with DONE=1, SUCCESS=0, counters frozen.
- HALT=1 sampled in RUN:
  - Entries matching in that same cycle are still evaluated.
  - Moves to DONE_S with DONE=1.
  - SUCCESS=1 iff FAIL=0 and PASS_CNT equals the number of armed entries.
  - Armed entries never reached count as not passed, so SUCCESS=0.
- Simultaneous first failure and HALT in stop mode: go to STOPPED; FAIL takes precedence.
- BUSY = (state == RUN).
- STOPPED and DONE_S hold all outputs until START or RST.
- Zero armed entries plus HALT gives SUCCESS=1.

Test Plan:
- Load entry 0 = (4, 0x0f00) and entry 1 = (6, 0x0018), START; drive NUM_INST=4/OUTPUT=0x0f00, NUM_INST=6/OUTPUT=0x0018, then HALT -> PASS_CNT=2, DONE=1, SUCCESS=1, FAIL=0.
- STOP_ON_FAIL=1, entry 5 = (0x0e, 0x0000); drive NUM_INST=0x0e with OUTPUT=0x0003 -> one cycle later FAIL=1, FAIL_IDX=5, FAIL_VAL=0x0003, DONE=1, SUCCESS=0; later NUM_INST changes leave outputs frozen.
- STOP_ON_FAIL=0, entries 2 and 3 both at count 0x10 expecting 0x1d and 0x1e; OUTPUT=0x1e -> PASS_CNT=1, FAIL_CNT=1, FAIL_IDX=2, run continues until HALT -> SUCCESS=0.
- NUM_INST held at 4 for 5 cycles with matching OUTPUT -> PASS_CNT=1, not 5; CYCLE increments each RUN cycle.
- Entry (0x1340, 1) armed, HALT at NUM_INST=0x100 -> DONE=1, SUCCESS=0, FAIL=0.
- RST asserted mid-run, then START without reloading the table -> all outputs 0 during reset; entries disarmed, so an immediate HALT gives PASS_CNT=0, SUCCESS=1.
